// File: rtl/counter_checker_pkg.sv
// Shared types and helpers for the counter_checker monitor.
// Holds the checker state enum, run-counter width and modulo-increment helper.
package counter_checker_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int unsigned LOCK_RUN_W = 4;

  function automatic logic [31:0] next_mod(
    input logic [31:0] value,
    input int unsigned width
  );
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/counter_checker_sat.sv
// Saturating incrementer with synchronous clear.
// Ports: clock, clear (sync), inc (step by one), value (holds at all-ones).
module counter_checker_sat #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [Width-1:0] value
);

  always_ff @(posedge clock) begin
    if (clear) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + Width'(1);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Passive monitor for a free-running modulo counter stream.
// Ports: clock, reset (sync, active-high), valid, count in;
//   locked, error, err_count, expected, err_expected, err_observed out.
// Option: COUNTER_CHECKER_CAPTURE_EN builds first-error capture registers.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int unsigned Size     = 5,
  parameter int unsigned LockRun  = 4,
  parameter int unsigned ErrWidth = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                valid,
  input  logic [Size-1:0]     count,
  output logic                locked,
  output logic                error,
  output logic [ErrWidth-1:0] err_count,
  output logic [Size-1:0]     expected,
  output logic [Size-1:0]     err_expected,
  output logic [Size-1:0]     err_observed
);

  state_t                state;
  state_t                state_nx;
  logic [LOCK_RUN_W-1:0] run;
  logic [LOCK_RUN_W-1:0] run_nx;
  logic                  hit;
  logic                  miss;

  assign hit    = (count == expected);
  assign locked = (state == LOCKED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
      run   <= '0;
    end else begin
      state <= state_nx;
      run   <= run_nx;
    end
  end

  always_comb begin
    state_nx = state;
    run_nx   = run;
    miss     = 1'b0;
    if (valid) begin
      unique case (state)
        EMPTY: begin
          state_nx = HUNT;
          run_nx   = '0;
        end
        HUNT: begin
          if (hit) begin
            run_nx = run + LOCK_RUN_W'(1);
            if (run_nx == LOCK_RUN_W'(LockRun)) begin
              state_nx = LOCKED;
            end
          end else begin
            run_nx = '0;
          end
        end
        LOCKED: begin
          if (!hit) begin
            miss     = 1'b1;
            run_nx   = '0;
            state_nx = HUNT;
          end
        end
        default: begin
          state_nx = EMPTY;
          run_nx   = '0;
        end
      endcase
    end
  end

  // The reference is refreshed on every sample so a glitch
  // resynchronises prediction immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      error    <= 1'b0;
      expected <= '0;
    end else begin
      error <= miss;
      if (valid) begin
        expected <= Size'(next_mod(32'(count), Size));
      end
    end
  end

  counter_checker_sat #(
    .Width(ErrWidth)
  ) u_sat (
    .clock(clock),
    .clear(reset),
    .inc  (miss),
    .value(err_count)
  );

`ifdef COUNTER_CHECKER_CAPTURE_EN
  logic captured;

  always_ff @(posedge clock) begin
    if (reset) begin
      captured     <= 1'b0;
      err_expected <= '0;
      err_observed <= '0;
    end else if (miss && !captured) begin
      captured     <= 1'b1;
      err_expected <= expected;
      err_observed <= count;
    end
  end
`else
  assign err_expected = '0;
  assign err_observed = '0;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: directed plan steps,
// then randomized traffic against a behavioural stream model.
module tb_counter_checker;

  localparam int SZ  = 5;
  localparam int LR  = 4;
  localparam int MOD = 1 << SZ;

  logic          clock = 1'b0;
  logic          reset;
  logic          valid;
  logic [SZ-1:0] count;

  logic          locked, error, locked2, error2;
  logic [7:0]    err_count;
  logic [1:0]    err_count2;
  logic [SZ-1:0] expected, err_expected, err_observed;
  logic [SZ-1:0] expected2, err_expected2, err_observed2;

  int compared   = 0;
  int mismatched = 0;

  bit m_have, m_lk, m_err, m_cap;
  int m_run, m_ec, m_ec2, m_exp, m_ce, m_co;

  always #5 clock = ~clock;

  counter_checker #(.Size(SZ), .LockRun(LR), .ErrWidth(8)) dut (
    .clock(clock), .reset(reset), .valid(valid), .count(count),
    .locked(locked), .error(error), .err_count(err_count),
    .expected(expected), .err_expected(err_expected),
    .err_observed(err_observed)
  );

  counter_checker #(.Size(SZ), .LockRun(LR), .ErrWidth(2)) dut2 (
    .clock(clock), .reset(reset), .valid(valid), .count(count),
    .locked(locked2), .error(error2), .err_count(err_count2),
    .expected(expected2), .err_expected(err_expected2),
    .err_observed(err_observed2)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  // Stream-level model: a sample matches when it is previous+1 mod 2^SZ;
  // LR consecutive matches after a seed give lock; a miss while locked
  // is an error.
  task automatic model(bit r, bit v, int c);
    if (r) begin
      m_have = 0; m_lk = 0; m_err = 0; m_cap = 0;
      m_run = 0; m_ec = 0; m_ec2 = 0; m_exp = 0; m_ce = 0; m_co = 0;
    end else begin
      m_err = 0;
      if (v) begin
        if (!m_have) begin
          m_have = 1;
          m_run  = 0;
        end else if (m_lk) begin
          if (c != m_exp) begin
            m_err = 1;
            m_lk  = 0;
            m_run = 0;
            if (m_ec < 255) m_ec++;
            if (m_ec2 < 3) m_ec2++;
            if (!m_cap) begin
              m_cap = 1; m_ce = m_exp; m_co = c;
            end
          end
        end else if (c == m_exp) begin
          m_run++;
          if (m_run >= LR) m_lk = 1;
        end else begin
          m_run = 0;
        end
        m_exp = (c + 1) % MOD;
      end
    end
  endtask

  task automatic step(bit r, bit v, int c);
    int ce, co;
    reset = r;
    valid = v;
    count = SZ'(c);
    model(r, v, c);
    @(posedge clock);
    #1;
`ifdef COUNTER_CHECKER_CAPTURE_EN
    ce = m_ce; co = m_co;
`else
    ce = 0; co = 0;
`endif
    check("locked", 32'(locked), 32'(m_lk));
    check("error", 32'(error), 32'(m_err));
    check("err_count", 32'(err_count), m_ec);
    check("expected", 32'(expected), m_exp);
    check("err_expected", 32'(err_expected), ce);
    check("err_observed", 32'(err_observed), co);
    check("locked2", 32'(locked2), 32'(m_lk));
    check("err_count2", 32'(err_count2), m_ec2);
  endtask

  initial begin
    bit r, v;
    int c;
    reset = 1'b1; valid = 1'b0; count = '0;

    step(1, 1, 7);
    check("rst_expected", 32'(expected), 0);
    check("rst_locked", 32'(locked), 0);

    for (int i = 0; i <= 5; i++) begin
      step(0, 1, i);
      if (i == 3) check("plan1_not_yet", 32'(locked), 0);
      if (i == 4) check("plan1_lock", 32'(locked), 1);
    end
    check("plan1_errcnt", 32'(err_count), 0);

    step(1, 0, 0);
    for (int i = 28; i < 36; i++) step(0, 1, i % MOD);
    check("wrap_locked", 32'(locked), 1);
    check("wrap_errcnt", 32'(err_count), 0);

    step(1, 0, 0);
    for (int i = 6; i <= 11; i++) step(0, 1, i);
    step(0, 1, 13);
    check("jump_error", 32'(error), 1);
    check("jump_errcnt", 32'(err_count), 1);
    check("jump_locked", 32'(locked), 0);
    check("jump_expected", 32'(expected), 14);
    step(0, 1, 14);
    check("jump_pulse", 32'(error), 0);
    for (int i = 15; i <= 17; i++) step(0, 1, i);
    check("relock", 32'(locked), 1);
`ifdef COUNTER_CHECKER_CAPTURE_EN
    check("cap_exp", 32'(err_expected), 12);
    check("cap_obs", 32'(err_observed), 13);
`endif

    step(1, 0, 0);
    for (int i = 2; i <= 6; i++) step(0, 1, i);
    step(0, 0, 0);
    step(0, 0, 21);
    step(0, 0, 9);
    step(0, 1, 7);
    check("gap_locked", 32'(locked), 1);
    check("gap_error", 32'(error), 0);

    step(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i <= 4; i++) step(0, 1, i);
      step(0, 1, 9);
      check("sat2", 32'(err_count2), (k < 3) ? k + 1 : 3);
    end
    check("sat8", 32'(err_count), 5);

    step(1, 0, 0);
    for (int i = 0; i <= 4; i++) step(0, 1, i);
    step(1, 1, 5);
    check("rst_lk_locked", 32'(locked), 0);
    check("rst_lk_expected", 32'(expected), 0);
    step(0, 1, 17);
    check("seed_expected", 32'(expected), 18);
    check("seed_locked", 32'(locked), 0);

    for (int n = 0; n < 600; n++) begin
      r = ($urandom % 50) == 0;
      v = ($urandom % 4) != 0;
      c = (($urandom % 6) == 0) ? int'($urandom % MOD) : m_exp;
      step(r, v, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
